// File: rtl/ni_flit_injector_pkg.sv
// Shared types and constants for the NI flit injector: geometry, header field
// offsets, credit counter width and the injector state encoding.
package ni_flit_injector_pkg;

   localparam int V    = 4;
   localparam int B    = 4;
   localparam int Fw   = 32;
   localparam int EAw  = 8;
   localparam int LENw = 8;

   localparam int Vw   = $clog2(V);
   localparam int CNTw = $clog2(B + 1);

   localparam int DEST_LSB = 0;
   localparam int SRC_LSB  = EAw;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HDR  = 2'd1,
      BODY = 2'd2
   } inj_state_t;

   function automatic logic [V-1:0] vc_onehot(input logic [Vw-1:0] vc);
      logic [V-1:0] oh;
      oh     = '0;
      oh[vc] = 1'b1;
      return oh;
   endfunction

endpackage

// File: rtl/ni_flit_injector_if.sv
// Packet request, payload and router local-port flit/credit channel of the
// injector, bundled so the core side and the router side see one port.
interface ni_flit_injector_if;
   import ni_flit_injector_pkg::*;

   // Handshakes: a packet request transfers on a cycle where pck_req_i and
   // pck_ready_o are both high; payload transfers where data_rd_o is high
   // (only while data_valid_i is high); each flit_wr_o pulse consumes one
   // credit of its VC and each credit_i bit returns one.
   logic              pck_req_i;
   logic              pck_ready_o;
   logic [EAw-1:0]    pck_dest_i;
   logic [LENw-1:0]   pck_len_i;
   logic [Vw-1:0]     pck_vc_i;
   logic              data_valid_i;
   logic [Fw-1:0]     data_i;
   logic              data_rd_o;
   logic              flit_wr_o;
   logic              flit_hdr_o;
   logic              flit_tail_o;
   logic [V-1:0]      flit_vc_o;
   logic [Fw-1:0]     flit_payload_o;
   logic [V-1:0]      credit_i;

   modport slave (
      input  pck_req_i, pck_dest_i, pck_len_i, pck_vc_i,
      input  data_valid_i, data_i, credit_i,
      output pck_ready_o, data_rd_o,
      output flit_wr_o, flit_hdr_o, flit_tail_o, flit_vc_o, flit_payload_o
   );

   modport master (
      output pck_req_i, pck_dest_i, pck_len_i, pck_vc_i,
      output data_valid_i, data_i, credit_i,
      input  pck_ready_o, data_rd_o,
      input  flit_wr_o, flit_hdr_o, flit_tail_o, flit_vc_o, flit_payload_o
   );

endinterface

// File: rtl/ni_flit_injector_credit_counter.sv
// Per-VC downstream buffer credit counter: starts full at B, saturates at
// both ends; a simultaneous send and return leaves it unchanged.
module inj_credit_counter
   import ni_flit_injector_pkg::*;
(
   input  logic            clk,
   input  logic            reset,
   input  logic            dec_i,
   input  logic            inc_i,
   output logic [CNTw-1:0] cnt_o,
   output logic            avail_o
);

   logic [CNTw-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (dec_i && !inc_i && cnt_q != '0)
         cnt_d = cnt_q - 1'b1;
      else if (inc_i && !dec_i && cnt_q != CNTw'(B))
         cnt_d = cnt_q + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) cnt_q <= CNTw'(B);
      else       cnt_q <= cnt_d;
   end

   assign cnt_o   = cnt_q;
   assign avail_o = (cnt_q != '0);

`ifndef SYNTHESIS
   // A returned credit with a full counter means the router returned more than was sent.
   credit_overflow_a: assert property (@(posedge clk) disable iff (reset)
      !(inc_i && !dec_i && cnt_q == CNTw'(B)))
      else $error("credit overflow on a full counter");
`endif

endmodule

// File: rtl/ni_flit_injector.sv
// Packet-to-flit injector for a router local port with per-VC credit flow control.
// Optional statistics counters are built when NI_INJECTOR_STAT_EN is defined.
module ni_flit_injector
   import ni_flit_injector_pkg::*;
(
   input  logic                   clk,
   input  logic                   reset,
   input  logic [EAw-1:0]         src_e_addr_i,
   ni_flit_injector_if.slave      bus,
`ifdef NI_INJECTOR_STAT_EN
   output logic [31:0]            pck_cnt_o,
   output logic [31:0]            flit_cnt_o,
   output logic [31:0]            stall_cnt_o,
`endif
   output logic [1:0]             state_o,
   output logic [V-1:0][CNTw-1:0] credit_dbg_o
);

   localparam logic [1:0] ST_IDLE = IDLE;
   localparam logic [1:0] ST_HDR  = HDR;
   localparam logic [1:0] ST_BODY = BODY;

   logic [1:0]      state_q, state_d;
   logic [EAw-1:0]  dest_q, dest_d;
   logic [Vw-1:0]   vc_q, vc_d;
   logic [LENw-1:0] rem_q, rem_d;

   logic            wr_q, wr_d;
   logic            hdr_q, hdr_d;
   logic            tail_q, tail_d;
   logic [V-1:0]    fvc_q, fvc_d;
   logic [Fw-1:0]   pay_q, pay_d;

   logic [V-1:0]    avail_vec;
   logic [V-1:0]    dec_vec;
   logic            cur_avail;
   logic            send_hdr, send_body, send, is_tail;

   assign cur_avail = avail_vec[vc_q];
   assign send_hdr  = (state_q == ST_HDR)  && cur_avail;
   assign send_body = (state_q == ST_BODY) && cur_avail && bus.data_valid_i;
   assign send      = send_hdr || send_body;
   assign is_tail   = (rem_q == LENw'(1));
   assign dec_vec   = send ? vc_onehot(vc_q) : '0;

   always_comb begin
      state_d = state_q;
      dest_d  = dest_q;
      vc_d    = vc_q;
      rem_d   = rem_q;
      wr_d    = send;
      hdr_d   = send_hdr;
      tail_d  = send && is_tail;
      fvc_d   = send ? vc_onehot(vc_q) : fvc_q;
      pay_d   = '0;
      if (send_hdr) begin
         pay_d[DEST_LSB +: EAw] = dest_q;
         pay_d[SRC_LSB  +: EAw] = src_e_addr_i;
      end else if (send_body) begin
         pay_d = bus.data_i;
      end
      case (state_q)
         ST_IDLE: begin
            if (bus.pck_req_i) begin
               dest_d  = bus.pck_dest_i;
               vc_d    = bus.pck_vc_i;
               // A zero-length request still carries a header, so it is a one-flit packet.
               rem_d   = (bus.pck_len_i == '0) ? LENw'(1) : bus.pck_len_i;
               state_d = ST_HDR;
            end
         end
         ST_HDR, ST_BODY: begin
            if (send) begin
               rem_d   = rem_q - 1'b1;
               state_d = is_tail ? ST_IDLE : ST_BODY;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         dest_q  <= '0;
         vc_q    <= '0;
         rem_q   <= '0;
         wr_q    <= 1'b0;
         hdr_q   <= 1'b0;
         tail_q  <= 1'b0;
         fvc_q   <= '0;
         pay_q   <= '0;
      end else begin
         state_q <= state_d;
         dest_q  <= dest_d;
         vc_q    <= vc_d;
         rem_q   <= rem_d;
         wr_q    <= wr_d;
         hdr_q   <= hdr_d;
         tail_q  <= tail_d;
         fvc_q   <= fvc_d;
         pay_q   <= pay_d;
      end
   end

   for (genvar v = 0; v < V; v++) begin : gen_cc
      inj_credit_counter u_cc (
         .clk     (clk),
         .reset   (reset),
         .dec_i   (dec_vec[v]),
         .inc_i   (bus.credit_i[v]),
         .cnt_o   (credit_dbg_o[v]),
         .avail_o (avail_vec[v])
      );
   end

   assign bus.pck_ready_o    = (state_q == ST_IDLE);
   assign bus.data_rd_o      = send_body;
   assign bus.flit_wr_o      = wr_q;
   assign bus.flit_hdr_o     = hdr_q;
   assign bus.flit_tail_o    = tail_q;
   assign bus.flit_vc_o      = fvc_q;
   assign bus.flit_payload_o = pay_q;
   assign state_o            = state_q;

`ifdef NI_INJECTOR_STAT_EN
   logic [31:0] pck_cnt_q, flit_cnt_q, stall_cnt_q;
   logic        stall;

   assign stall = ((state_q == ST_HDR) || (state_q == ST_BODY)) && !cur_avail;

   always_ff @(posedge clk) begin
      if (reset) begin
         pck_cnt_q   <= '0;
         flit_cnt_q  <= '0;
         stall_cnt_q <= '0;
      end else begin
         if (send && is_tail) pck_cnt_q   <= pck_cnt_q + 32'd1;
         if (send)            flit_cnt_q  <= flit_cnt_q + 32'd1;
         if (stall)           stall_cnt_q <= stall_cnt_q + 32'd1;
      end
   end

   assign pck_cnt_o   = pck_cnt_q;
   assign flit_cnt_o  = flit_cnt_q;
   assign stall_cnt_o = stall_cnt_q;
`endif

endmodule
